// File: rtl/atc_runway_scheduler_pkg.sv
// Shared types for the BobATC runway scheduler: reply messages, FSM states and grant sources.
package atc_runway_scheduler_pkg;

   typedef enum logic [2:0] {
      T_HOLD   = 3'd0,
      T_CLEAR  = 3'd1,
      T_DIVERT = 3'd2
   } msg_type_t;

   typedef enum logic [1:0] {
      S_NORMAL,
      S_EMERG_PEND,
      S_EMERG_LAND
   } sched_state_t;

   typedef enum logic [1:0] {
      G_NONE,
      G_EMERG,
      G_LAND,
      G_TAKEOFF
   } grant_src_t;

   function automatic int rw_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/atc_runway_scheduler_if.sv
// Request, release and reply handshake bundle between the decoder, the scheduler and the reply path.
interface atc_runway_scheduler_if
   import atc_runway_scheduler_pkg::*;
#(
   parameter int NUM_RUNWAYS = 2,
   parameter int ID_W        = 4
);
   localparam int RW_W = rw_width(NUM_RUNWAYS);

   logic            req_valid;
   logic            req_ready;
   logic [ID_W-1:0] req_id;
   logic            req_kind;
   logic            req_emergency;
   logic            rel_valid;
   logic [RW_W-1:0] rel_runway;
   logic            reply_valid;
   logic            reply_ready;
   msg_type_t       reply_type;
   logic [ID_W-1:0] reply_id;
   logic [RW_W-1:0] reply_runway;
   logic            reply_takeoff;

   modport master (
      output req_valid, req_id, req_kind, req_emergency, rel_valid, rel_runway, reply_ready,
      input  req_ready, reply_valid, reply_type, reply_id, reply_runway, reply_takeoff
   );

   modport slave (
      input  req_valid, req_id, req_kind, req_emergency, rel_valid, rel_runway, reply_ready,
      output req_ready, reply_valid, reply_type, reply_id, reply_runway, reply_takeoff
   );

endinterface

// File: rtl/atc_id_queue.sv
// Plane-id FIFO with modulo-DEPTH pointers, so any depth works, not only powers of two.
module atc_id_queue #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 15
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             din,
   output logic [WIDTH-1:0]             head,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wrap_inc(wr_ptr);
         if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/atc_runway_scheduler.sv
// Runway allocator: queues takeoff/landing requests, grants free runways with landing priority
// under a burst limit, handles one emergency at a time, and emits one reply per event.
module atc_runway_scheduler
   import atc_runway_scheduler_pkg::*;
#(
   parameter int NUM_RUNWAYS = 2,
   parameter int QUEUE_DEPTH = 15,
   parameter int ID_W        = 4,
   parameter int LAND_BURST  = 3
) (
   input  logic                    clock,
   input  logic                    reset_n,
   atc_runway_scheduler_if.slave   bus,
   output logic [NUM_RUNWAYS-1:0]  runway_occupied,
   output logic                    emergency_active
);
   localparam int RW_W = rw_width(NUM_RUNWAYS);
   localparam int CW   = $clog2(QUEUE_DEPTH + 1);
   localparam int BW   = $clog2(LAND_BURST + 1);

   sched_state_t     state, state_next;
   grant_src_t       src;
   logic [ID_W-1:0]  emerg_id;
   logic [RW_W-1:0]  emerg_rw;
   logic [BW-1:0]    burst;
   logic [RW_W-1:0]  free_rw;
   logic             any_free, slot_free, grant_now, accept;
   logic [NUM_RUNWAYS-1:0] rel_mask, grant_mask;

   logic             land_push, land_pop, land_full, land_empty;
   logic             to_push, to_pop, to_full, to_empty;
   logic [ID_W-1:0]  land_head, to_head;
   logic [CW-1:0]    land_count, to_count;
   logic             unused_counts;

   logic             ld;
   msg_type_t        nxt_type;
   logic [ID_W-1:0]  nxt_id;
   logic [RW_W-1:0]  nxt_rw;
   logic             nxt_to;

   atc_id_queue #(.WIDTH(ID_W), .DEPTH(QUEUE_DEPTH)) u_land (
      .clock(clock), .reset_n(reset_n), .push(land_push), .pop(land_pop), .din(bus.req_id),
      .head(land_head), .count(land_count), .full(land_full), .empty(land_empty)
   );

   atc_id_queue #(.WIDTH(ID_W), .DEPTH(QUEUE_DEPTH)) u_takeoff (
      .clock(clock), .reset_n(reset_n), .push(to_push), .pop(to_pop), .din(bus.req_id),
      .head(to_head), .count(to_count), .full(to_full), .empty(to_empty)
   );

   assign unused_counts = ^{land_count, to_count};

   always_comb begin
      free_rw  = '0;
      any_free = 1'b0;
      for (int i = NUM_RUNWAYS - 1; i >= 0; i--) begin
         if (!runway_occupied[i]) begin
            free_rw  = RW_W'(i);
            any_free = 1'b1;
         end
      end
   end

   // A pending emergency blocks every normal grant until it is itself granted.
   always_comb begin
      src = G_NONE;
      if (state == S_EMERG_PEND)
         src = G_EMERG;
      else if (!land_empty && !(burst == BW'(LAND_BURST) && !to_empty))
         src = G_LAND;
      else if (!to_empty)
         src = G_TAKEOFF;
   end

   assign slot_free        = !bus.reply_valid || bus.reply_ready;
   assign grant_now        = slot_free && any_free && (src != G_NONE);
   assign bus.req_ready    = reset_n && slot_free && !grant_now;
   assign accept           = bus.req_valid && bus.req_ready;
   assign land_push        = accept && !bus.req_emergency && bus.req_kind && !land_full;
   assign to_push          = accept && !bus.req_emergency && !bus.req_kind && !to_full;
   assign land_pop         = grant_now && (src == G_LAND);
   assign to_pop           = grant_now && (src == G_TAKEOFF);
   assign emergency_active = (state != S_NORMAL);

   always_comb begin
      for (int i = 0; i < NUM_RUNWAYS; i++) begin
         rel_mask[i]   = bus.rel_valid && (bus.rel_runway == RW_W'(i));
         grant_mask[i] = grant_now && (free_rw == RW_W'(i));
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         S_NORMAL:     if (accept && bus.req_emergency) state_next = S_EMERG_PEND;
         S_EMERG_PEND: if (grant_now) state_next = S_EMERG_LAND;
         S_EMERG_LAND: if (bus.rel_valid && bus.rel_runway == emerg_rw) state_next = S_NORMAL;
         default:      state_next = S_NORMAL;
      endcase
   end

   always_comb begin
      ld       = 1'b0;
      nxt_type = T_HOLD;
      nxt_id   = bus.req_id;
      nxt_rw   = '0;
      nxt_to   = 1'b0;
      if (grant_now) begin
         ld       = 1'b1;
         nxt_type = T_CLEAR;
         nxt_rw   = free_rw;
         unique case (src)
            G_EMERG: nxt_id = emerg_id;
            G_LAND:  nxt_id = land_head;
            default: begin
               nxt_id = to_head;
               nxt_to = 1'b1;
            end
         endcase
      end else if (accept) begin
         ld = 1'b1;
         if (bus.req_emergency)
            nxt_type = (state == S_NORMAL) ? T_HOLD : T_DIVERT;
         else if (bus.req_kind)
            nxt_type = land_full ? T_DIVERT : T_HOLD;
         else
            nxt_type = to_full ? T_DIVERT : T_HOLD;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state             <= S_NORMAL;
         runway_occupied   <= '0;
         burst             <= '0;
         bus.reply_valid   <= 1'b0;
         bus.reply_type    <= T_HOLD;
         bus.reply_id      <= '0;
         bus.reply_runway  <= '0;
         bus.reply_takeoff <= 1'b0;
      end else begin
         state           <= state_next;
         runway_occupied <= (runway_occupied & ~rel_mask) | grant_mask;
         if (to_pop || to_empty)
            burst <= '0;
         else if (land_pop && burst != BW'(LAND_BURST))
            burst <= burst + 1'b1;
         if (ld) begin
            bus.reply_valid   <= 1'b1;
            bus.reply_type    <= nxt_type;
            bus.reply_id      <= nxt_id;
            bus.reply_runway  <= nxt_rw;
            bus.reply_takeoff <= nxt_to;
         end else if (bus.reply_ready) begin
            bus.reply_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (accept && bus.req_emergency && state == S_NORMAL) emerg_id <= bus.req_id;
      if (grant_now && src == G_EMERG) emerg_rw <= free_rw;
   end

endmodule

// File: tb/tb_atc_runway_scheduler.sv
// Directed, table-driven bench for the runway scheduler (2 runways, depth 15, burst 3).
module tb_atc_runway_scheduler;
   import atc_runway_scheduler_pkg::*;

   localparam int NR = 2;
   localparam int IDW = 4;
   localparam int IDLE = 0, TK = 1, LD = 2, EM = 3, REL = 4;

   logic          clock = 1'b0;
   logic          reset_n;
   logic [NR-1:0] runway_occupied;
   logic          emergency_active;

   atc_runway_scheduler_if #(.NUM_RUNWAYS(NR), .ID_W(IDW)) bus ();

   atc_runway_scheduler #(.NUM_RUNWAYS(NR), .QUEUE_DEPTH(15), .ID_W(IDW), .LAND_BURST(3)) dut (
      .clock(clock), .reset_n(reset_n), .bus(bus),
      .runway_occupied(runway_occupied), .emergency_active(emergency_active)
   );

   always #5 clock = ~clock;

   typedef struct {
      int         op;
      logic [3:0] id;
      logic       rr;
      logic       e_rdy;
      logic       e_val;
      logic [2:0] e_typ;
      logic [3:0] e_id;
      logic       e_rw;
      logic       e_to;
      logic [1:0] e_occ;
      logic       e_em;
   } vec_t;

   vec_t  tbl[$];
   int    vectors = 0;
   int    miscompares = 0;
   string phase;

   task automatic add(input int op, input logic [3:0] id, input logic rr, input logic e_rdy,
                      input logic e_val, input logic [2:0] e_typ, input logic [3:0] e_id,
                      input logic e_rw, input logic e_to, input logic [1:0] e_occ, input logic e_em);
      vec_t v;
      v.op = op; v.id = id; v.rr = rr; v.e_rdy = e_rdy; v.e_val = e_val; v.e_typ = e_typ;
      v.e_id = e_id; v.e_rw = e_rw; v.e_to = e_to; v.e_occ = e_occ; v.e_em = e_em;
      tbl.push_back(v);
   endtask

   task automatic drive_idle();
      bus.req_valid = 1'b0; bus.req_id = '0; bus.req_kind = 1'b0; bus.req_emergency = 1'b0;
      bus.rel_valid = 1'b0; bus.rel_runway = '0; bus.reply_ready = 1'b1;
   endtask

   // Called at posedge+1; req_ready sampled mid-cycle, registered outputs sampled after the edge.
   task automatic apply(input vec_t v, input int idx);
      logic rdy_s;
      logic ok;
      bus.req_valid     = (v.op == TK || v.op == LD || v.op == EM);
      bus.req_id        = v.id;
      bus.req_kind      = (v.op == LD);
      bus.req_emergency = (v.op == EM);
      bus.rel_valid     = (v.op == REL);
      bus.rel_runway    = v.id[0];
      bus.reply_ready   = v.rr;
      #3 rdy_s = bus.req_ready;
      @(posedge clock); #1;
      ok = (rdy_s == v.e_rdy) && (bus.reply_valid == v.e_val) && (runway_occupied == v.e_occ) &&
           (emergency_active == v.e_em) &&
           (!v.e_val || (bus.reply_type == v.e_typ && bus.reply_id == v.e_id &&
                         bus.reply_runway == v.e_rw && bus.reply_takeoff == v.e_to));
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL %s vec %0d: got rdy=%0b val=%0b typ=%0d id=%0d rw=%0d to=%0b occ=%b em=%0b; want rdy=%0b val=%0b typ=%0d id=%0d rw=%0d to=%0b occ=%b em=%0b",
                  phase, idx, rdy_s, bus.reply_valid, bus.reply_type, bus.reply_id, bus.reply_runway,
                  bus.reply_takeoff, runway_occupied, emergency_active, v.e_rdy, v.e_val, v.e_typ,
                  v.e_id, v.e_rw, v.e_to, v.e_occ, v.e_em);
      end
   endtask

   task automatic run(input string name);
      phase = name;
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);
      tbl.delete();
      drive_idle();
   endtask

   task automatic check_zero(input string name, input logic e_rdy);
      logic ok;
      ok = (bus.req_ready == e_rdy) && !bus.reply_valid && (bus.reply_type == T_HOLD) &&
           (bus.reply_id == '0) && (bus.reply_runway == '0) && !bus.reply_takeoff &&
           (runway_occupied == '0) && !emergency_active;
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL %s: got rdy=%0b val=%0b typ=%0d id=%0d rw=%0d to=%0b occ=%b em=%0b; want rdy=%0b and all else 0",
                  name, bus.req_ready, bus.reply_valid, bus.reply_type, bus.reply_id,
                  bus.reply_runway, bus.reply_takeoff, runway_occupied, emergency_active, e_rdy);
      end
   endtask

   task automatic do_reset(input string name);
      drive_idle();
      reset_n = 1'b0;
      #1 check_zero({name, "_asserted"}, 1'b0);
      @(posedge clock);
      @(negedge clock) reset_n = 1'b1;
      @(posedge clock); #1;
      check_zero({name, "_released"}, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      drive_idle();
      reset_n = 1'b1;
      #2 do_reset("reset_initial");

      // Basic landing + takeoff: grants take the reply slot ahead of new requests.
      add(LD,   3, 1, 1, 1, T_HOLD,  3, 0, 0, 2'b00, 0);
      add(TK,   5, 1, 0, 1, T_CLEAR, 3, 0, 0, 2'b01, 0);
      add(TK,   5, 1, 1, 1, T_HOLD,  5, 0, 0, 2'b01, 0);
      add(IDLE, 0, 1, 0, 1, T_CLEAR, 5, 1, 1, 2'b11, 0);
      add(IDLE, 0, 1, 1, 0, T_HOLD,  0, 0, 0, 2'b11, 0);
      run("basic");

      // Takeoff queue fills to 15, then diverts; head comes out first once a runway frees.
      for (int i = 0; i < 15; i++) add(TK, 4'(i), 1, 1, 1, T_HOLD, 4'(i), 0, 0, 2'b11, 0);
      add(TK,    9, 1, 1, 1, T_DIVERT,  9, 0, 0, 2'b11, 0);
      add(TK,   10, 1, 1, 1, T_DIVERT, 10, 0, 0, 2'b11, 0);
      add(REL,   0, 1, 1, 0, T_HOLD,    0, 0, 0, 2'b10, 0);
      add(IDLE,  0, 1, 0, 1, T_CLEAR,   0, 0, 1, 2'b11, 0);
      run("queue_full");

      do_reset("reset_burst");

      // Occupy both runways with takeoffs, queue 5 landings + 1 takeoff, cycle runway 1.
      add(TK,    1, 1, 1, 1, T_HOLD,   1, 0, 0, 2'b00, 0);
      add(TK,    2, 1, 0, 1, T_CLEAR,  1, 0, 1, 2'b01, 0);
      add(TK,    2, 1, 1, 1, T_HOLD,   2, 0, 0, 2'b01, 0);
      add(LD,   10, 1, 0, 1, T_CLEAR,  2, 1, 1, 2'b11, 0);
      for (int i = 10; i < 15; i++) add(LD, 4'(i), 1, 1, 1, T_HOLD, 4'(i), 0, 0, 2'b11, 0);
      add(TK,    6, 1, 1, 1, T_HOLD,   6, 0, 0, 2'b11, 0);
      add(REL,   1, 1, 1, 0, T_HOLD,   0, 0, 0, 2'b01, 0);
      add(IDLE,  0, 1, 0, 1, T_CLEAR, 10, 1, 0, 2'b11, 0);
      add(REL,   1, 1, 1, 0, T_HOLD,   0, 0, 0, 2'b01, 0);
      add(IDLE,  0, 1, 0, 1, T_CLEAR, 11, 1, 0, 2'b11, 0);
      add(REL,   1, 1, 1, 0, T_HOLD,   0, 0, 0, 2'b01, 0);
      add(IDLE,  0, 1, 0, 1, T_CLEAR, 12, 1, 0, 2'b11, 0);
      add(REL,   1, 1, 1, 0, T_HOLD,   0, 0, 0, 2'b01, 0);
      add(IDLE,  0, 1, 0, 1, T_CLEAR,  6, 1, 1, 2'b11, 0);
      add(REL,   1, 1, 1, 0, T_HOLD,   0, 0, 0, 2'b01, 0);
      add(IDLE,  0, 1, 0, 1, T_CLEAR, 13, 1, 0, 2'b11, 0);
      add(REL,   1, 1, 1, 0, T_HOLD,   0, 0, 0, 2'b01, 0);
      add(IDLE,  0, 1, 0, 1, T_CLEAR, 14, 1, 0, 2'b11, 0);
      add(IDLE,  0, 1, 1, 0, T_HOLD,   0, 0, 0, 2'b11, 0);
      run("burst");

      // Emergency overtakes queued landings; a second emergency is diverted.
      add(LD,    3, 1, 1, 1, T_HOLD,   3, 0, 0, 2'b11, 0);
      add(LD,    4, 1, 1, 1, T_HOLD,   4, 0, 0, 2'b11, 0);
      add(EM,    7, 1, 1, 1, T_HOLD,   7, 0, 0, 2'b11, 1);
      add(REL,   1, 1, 1, 0, T_HOLD,   0, 0, 0, 2'b01, 1);
      add(IDLE,  0, 1, 0, 1, T_CLEAR,  7, 1, 0, 2'b11, 1);
      add(EM,    8, 1, 1, 1, T_DIVERT, 8, 0, 0, 2'b11, 1);
      add(REL,   1, 1, 1, 0, T_HOLD,   0, 0, 0, 2'b01, 0);
      add(IDLE,  0, 1, 0, 1, T_CLEAR,  3, 1, 0, 2'b11, 0);
      run("emergency");

      // Backpressure on a pending T_CLEAR, plus release of an already-free runway.
      add(REL,   0, 1, 1, 0, T_HOLD,   0, 0, 0, 2'b10, 0);
      add(IDLE,  0, 0, 0, 1, T_CLEAR,  4, 0, 0, 2'b11, 0);
      add(REL,   1, 0, 0, 1, T_CLEAR,  4, 0, 0, 2'b01, 0);
      add(REL,   1, 0, 0, 1, T_CLEAR,  4, 0, 0, 2'b01, 0);
      add(LD,    9, 0, 0, 1, T_CLEAR,  4, 0, 0, 2'b01, 0);
      add(LD,    9, 0, 0, 1, T_CLEAR,  4, 0, 0, 2'b01, 0);
      add(LD,    9, 1, 1, 1, T_HOLD,   9, 0, 0, 2'b01, 0);
      add(IDLE,  0, 1, 0, 1, T_CLEAR,  9, 1, 0, 2'b11, 0);
      add(IDLE,  0, 1, 1, 0, T_HOLD,   0, 0, 0, 2'b11, 0);
      run("backpressure");

      // Three requests queued with both runways busy, then an asynchronous reset mid-cycle.
      add(LD,    1, 1, 1, 1, T_HOLD,   1, 0, 0, 2'b11, 0);
      add(LD,    2, 1, 1, 1, T_HOLD,   2, 0, 0, 2'b11, 0);
      add(TK,    3, 1, 1, 1, T_HOLD,   3, 0, 0, 2'b11, 0);
      run("pre_reset");
      #1 do_reset("reset_mid");
      add(LD,    5, 1, 1, 1, T_HOLD,   5, 0, 0, 2'b00, 0);
      add(IDLE,  0, 1, 0, 1, T_CLEAR,  5, 0, 0, 2'b01, 0);
      add(IDLE,  0, 1, 1, 0, T_HOLD,   0, 0, 0, 2'b01, 0);
      run("post_reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
